hello_scroller: RTL

HELLO_SCROLLER -- requirements
Module: hello_scroller

---
 rtl/hello_scroller_pkg.sv | 36 +++
 rtl/hello_scroller_if.sv | 27 ++
 rtl/char_7seg3.sv | 22 ++
 rtl/hello_scroller.sv | 118 +++++++++++
 4 files changed

// File: rtl/hello_scroller_pkg.sv
// Shared constants for the HELLO scroller: character codes, segment patterns,
// scroll FSM states and the power-up message contents.
package scroll_pkg;

  localparam logic [2:0] CH_H     = 3'b000;
  localparam logic [2:0] CH_E     = 3'b001;
  localparam logic [2:0] CH_L     = 3'b010;
  localparam logic [2:0] CH_O     = 3'b011;
  localparam logic [2:0] CH_BLANK = 3'b100;

  // Active-low segment patterns, bit k = segment k (a..g)
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } scroll_state_e;

  // Message contents after reset: "HELLO" followed by blanks
  function automatic logic [2:0] resetChar(input int idx);
    logic [2:0] ch;
    case (idx)
      0:       ch = CH_H;
      1:       ch = CH_E;
      2, 3:    ch = CH_L;
      4:       ch = CH_O;
      default: ch = CH_BLANK;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/hello_scroller_if.sv
// Control/write/display bundle between a host and the HELLO scroller.
// The write address carries one spare bit so that addresses past the end of
// the buffer can be presented and are then rejected by the scroller.
interface hello_scroller_if #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 8
);
  localparam int ADDR_W = $clog2(MSG_LEN) + 1;

  logic                    Run;
  logic                    Dir;
  logic                    Step;
  logic                    Wr;
  logic [ADDR_W-1:0]       WrAddr;
  logic [2:0]              WrData;
  logic [7*NUM_DIGITS-1:0] HEX;

  modport master (
    output Run, Dir, Step, Wr, WrAddr, WrData,
    input  HEX
  );

  modport slave (
    input  Run, Dir, Step, Wr, WrAddr, WrData,
    output HEX
  );
endinterface

// File: rtl/char_7seg3.sv
// Combinational decoder from a 3-bit character code to an active-low
// seven-segment pattern.
module char_7seg3
  import scroll_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern; any code with the top bit set is blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      CH_H:    seg_o = SEG_H;
      CH_E:    seg_o = SEG_E;
      CH_L:    seg_o = SEG_L;
      CH_O:    seg_o = SEG_O;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hello_scroller.sv
// Scrolls a small character buffer across a row of seven-segment digits,
// either automatically on a prescaled tick or one position per Step pulse.
module hello_scroller
  import scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  hello_scroller_if.slave bus
);

  localparam int OFF_W  = $clog2(MSG_LEN);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int ADDR_W = $clog2(MSG_LEN) + 1;

  scroll_state_e           state_q, state_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [2:0]              msg_q [MSG_LEN];
  logic [2:0]              msg_d [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [7*NUM_DIGITS-1:0] segWindow;
  logic                    tickStep;
  logic                    doStep;
  logic                    wrOk;

  // Mode register; everything else keys off whether we are running
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) state_q <= ST_PAUSE;
    else       state_q <= state_d;
  end

  // Mode follows Run; prescaler counts only while running and is held at zero
  // while paused so every entry into RUN starts a full tick period
  always_comb begin
    state_d  = bus.Run ? ST_RUN : ST_PAUSE;
    presc_d  = '0;
    tickStep = 1'b0;
    doStep   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (presc_q == PRE_W'(TICK_DIV - 1)) begin
          presc_d  = '0;
          tickStep = 1'b1;
        end else begin
          presc_d  = presc_q + PRE_W'(1);
        end
        doStep = tickStep;
      end
      default: begin
        presc_d = '0;
        doStep  = bus.Step;
      end
    endcase
  end

  // Prescaler register
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Window offset moves one position per step, direction sampled on that cycle
  always_comb begin
    off_d = off_q;
    if (doStep) begin
      if (bus.Dir) off_d = (off_q == '0) ? OFF_W'(MSG_LEN - 1) : off_q - OFF_W'(1);
      else         off_d = (off_q == OFF_W'(MSG_LEN - 1)) ? '0 : off_q + OFF_W'(1);
    end
  end

  // Offset register
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) off_q <= '0;
    else       off_q <= off_d;
  end

  assign wrOk = bus.Wr && (bus.WrAddr < ADDR_W'(MSG_LEN));

  // Buffer write path, independent of mode and of stepping
  always_comb begin
    msg_d = msg_q;
    if (wrOk) msg_d[bus.WrAddr[OFF_W-1:0]] = bus.WrData;
  end

  // Message buffer, reloaded with HELLO on reset
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= resetChar(i);
    end else begin
      msg_q <= msg_d;
    end
  end

  // Leftmost digit (highest index) shows msg[off], wrapping around the buffer
  for (genvar j = 0; j < NUM_DIGITS; j++) begin : gDigit
    logic [OFF_W-1:0] winIdx;
    assign winIdx = OFF_W'((int'(off_q) + (NUM_DIGITS - 1 - j)) % MSG_LEN);
    char_7seg3 uDec (
      .code_i (msg_q[winIdx]),
      .seg_o  (segWindow[7*j +: 7])
    );
  end

  assign hex_d = segWindow;

  // Registered display, blank while in reset
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) hex_q <= {NUM_DIGITS{SEG_BLANK}};
    else       hex_q <= hex_d;
  end

  assign bus.HEX = hex_q;

endmodule
